// File: rtl/execute_pkg.sv
// execute_pkg: shared types and constants for the TinyRisc execute stage.
//   alu_op_t     - 4-bit operation codes (14 and 15 are reserved, act as NOP)
//   exec_state_t - execute-stage FSM states
//   DIV_STEPS    - restoring-division iterations per divide
//   DIV0_QUOT    - quotient returned for a divide by zero
package execute_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_CMP = 4'd5,
        OP_AND = 4'd6,
        OP_OR  = 4'd7,
        OP_NOT = 4'd8,
        OP_MOV = 4'd9,
        OP_LSL = 4'd10,
        OP_LSR = 4'd11,
        OP_ASR = 4'd12,
        OP_NOP = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2
    } exec_state_t;

    localparam int          DIV_STEPS = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/execute_if.sv
// execute_if: bundle between the decode stage (master) and the execute
// stage (slave), including the registered outputs toward the memory stage.
//
// Handshake: an instruction transfers on a rising edge where
// in_valid && in_ready && !flush. in_valid never depends on in_ready.
// out_valid is a one-cycle pulse with no ready; the memory stage always
// takes it. flush kills the in-flight op and anything offered that cycle.
interface execute_if;
    import execute_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         op1;
    logic [31:0]         op2;
    logic [31:0]         immx;
    logic                is_immediate;
    logic                in_is_ld;
    logic                in_is_st;
    logic                out_valid;
    logic [31:0]         alu_result;
    logic [31:0]         st_data;
    logic                out_is_ld;
    logic                out_is_st;
    logic                flag_e;
    logic                flag_gt;

    modport master (
        output in_valid, flush, alu_op, op1, op2, immx, is_immediate,
               in_is_ld, in_is_st,
        input  in_ready, out_valid, alu_result, st_data, out_is_ld,
               out_is_st, flag_e, flag_gt
    );

    modport slave (
        input  in_valid, flush, alu_op, op1, op2, immx, is_immediate,
               in_is_ld, in_is_st,
        output in_ready, out_valid, alu_result, st_data, out_is_ld,
               out_is_st, flag_e, flag_gt
    );
endinterface

// File: rtl/execute_unit_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
//   start     - load dividend/divisor (ignored while abort is high)
//   abort     - drop the current divide
//   busy      - division steps in progress
//   done      - combinational: the step on this edge is the last one;
//               quotient/remainder are final after this edge
//   quotient, remainder - unsigned results
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor; a borrow (diff MSB) means keep the old value.
    always_comb begin
        rem_sh   = {remainder, quotient[WIDTH-1]};
        diff     = rem_sh - {1'b0, dvs_q};
        rem_next = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {quotient[WIDTH-2:0], ~diff[WIDTH]};
    end

    assign done = busy && (count == LAST) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            count     <= '0;
            dvs_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            count     <= '0;
            dvs_q     <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (busy) begin
            quotient  <= quo_next;
            remainder <= rem_next;
            if (count == LAST) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/execute_unit.sv
// execute_unit: TinyRisc execute stage.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - execute_if slave: instruction in, result/qualifiers out,
//                CMP flags
//   dbg_state  - current FSM state (IDLE/DIV/FIX)
// Single-cycle ops register their result at the accept edge. DIV/MOD run
// on the sign-magnitude seq_divider; signs and special cases are fixed up
// here in the FIX state.
module execute_unit
    import execute_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    execute_if.slave    bus,
    output exec_state_t dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a, op_b, alu_comb;
    logic             accept, is_div_op, div_start, div_abort;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             div_busy, div_done;
    logic [WIDTH-1:0] div_quo, div_rem, div_final;
    logic             neg_q, neg_r, div_zero, is_mod;
    logic [WIDTH-1:0] dividend_q;
    logic             ld_q, st_q;

    assign op_a      = bus.op1;
    assign op_b      = bus.is_immediate ? bus.immx : bus.op2;
    assign bus.in_ready = (state == S_IDLE);
    assign accept    = bus.in_valid && bus.in_ready && !bus.flush;
    assign is_div_op = DIV_EN && (bus.alu_op == OP_DIV || bus.alu_op == OP_MOD);
    assign div_start = accept && is_div_op;
    assign div_abort = bus.flush && (state != S_IDLE);
    assign dbg_state = exec_state_t'(state);

    // -MIN wraps back to MIN, which is the correct unsigned magnitude.
    assign a_abs = op_a[WIDTH-1] ? -op_a : op_a;
    assign b_abs = op_b[WIDTH-1] ? -op_b : op_b;

    always_comb begin
        alu_comb = '0;
        case (bus.alu_op)
            OP_ADD:  alu_comb = op_a + op_b;
            OP_SUB:  alu_comb = op_a - op_b;
            OP_MUL:  alu_comb = op_a * op_b;
            OP_AND:  alu_comb = op_a & op_b;
            OP_OR:   alu_comb = op_a | op_b;
            OP_NOT:  alu_comb = ~op_b;
            OP_MOV:  alu_comb = op_b;
            OP_LSL:  alu_comb = op_a << op_b[4:0];
            OP_LSR:  alu_comb = op_a >> op_b[4:0];
            OP_ASR:  alu_comb = $signed(op_a) >>> op_b[4:0];
            default: alu_comb = '0;
        endcase
    end

    // MIN / -1 needs no special case: |MIN|/1 = MIN, and negating it
    // leaves MIN with remainder 0.
    always_comb begin
        if (div_zero)
            div_final = is_mod ? dividend_q : DIV0_QUOT;
        else if (is_mod)
            div_final = neg_r ? -div_rem : div_rem;
        else
            div_final = neg_q ? -div_quo : div_quo;
    end

    generate
        if (DIV_EN) begin : g_div
            seq_divider #(.WIDTH(WIDTH)) u_div (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (div_start),
                .abort     (div_abort),
                .dividend  (a_abs),
                .divisor   (b_abs),
                .busy      (div_busy),
                .done      (div_done),
                .quotient  (div_quo),
                .remainder (div_rem)
            );
        end else begin : g_no_div
            assign div_busy = 1'b0;
            assign div_done = 1'b0;
            assign div_quo  = '0;
            assign div_rem  = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bus.out_valid  <= 1'b0;
            bus.alu_result <= '0;
            bus.st_data    <= '0;
            bus.flag_e     <= 1'b0;
            bus.flag_gt    <= 1'b0;
            ld_q           <= 1'b0;
            st_q           <= 1'b0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            div_zero       <= 1'b0;
            is_mod         <= 1'b0;
            dividend_q     <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus.st_data <= bus.op2;
                        ld_q        <= bus.in_is_ld;
                        st_q        <= bus.in_is_st;
                        if (is_div_op) begin
                            state      <= S_DIV;
                            neg_q      <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            neg_r      <= op_a[WIDTH-1];
                            div_zero   <= (op_b == '0);
                            is_mod     <= (bus.alu_op == OP_MOD);
                            dividend_q <= op_a;
                        end else begin
                            bus.out_valid  <= 1'b1;
                            bus.alu_result <= alu_comb;
                            if (bus.alu_op == OP_CMP) begin
                                bus.flag_e  <= (op_a == op_b);
                                bus.flag_gt <= ($signed(op_a) > $signed(op_b));
                            end
                        end
                    end
                end
                S_DIV: begin
                    if (bus.flush)
                        state <= S_IDLE;
                    else if (div_done || !div_busy)
                        state <= S_FIX;
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!bus.flush) begin
                        bus.out_valid  <= 1'b1;
                        bus.alu_result <= div_final;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_is_ld = bus.out_valid & ld_q;
    assign bus.out_is_st = bus.out_valid & st_q;
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed checks of the execute stage. Inputs change 1ns
// after a rising edge; outputs are checked at that same point.
module tb_execute_unit;
    import execute_pkg::*;

    logic        clk;
    logic        rst_n;
    exec_state_t dbg_state;
    int          total;
    int          bad;
    int          lat;
    int          rdy_bad;
    int          pulses;

    execute_if bus ();

    execute_unit #(.WIDTH(32), .DIV_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic isimm, input logic ld, input logic st);
        bus.alu_op       = op;
        bus.op1          = a;
        bus.op2          = b;
        bus.immx         = imm;
        bus.is_immediate = isimm;
        bus.in_is_ld     = ld;
        bus.in_is_st     = st;
        bus.in_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges after the accept until out_valid, bounded at 40.
    task automatic wait_result(output int n, output int ready_errs);
        n = 0;
        ready_errs = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_valid) break;
            if (bus.in_ready) ready_errs++;
        end
    endtask

    task automatic do_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        send(op, a, b, 32'h0, 1'b0, 1'b0, 1'b0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_DIV));
        wait_result(lat, rdy_bad);
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
        check({tag, "_result"}, bus.alu_result, exp);
        check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.alu_op = 4'd0;
        bus.op1 = '0;
        bus.op2 = '0;
        bus.immx = '0;
        bus.is_immediate = 1'b0;
        bus.in_is_ld = 1'b0;
        bus.in_is_st = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.alu_result, 32'd0);
        check("rst_flags", {30'd0, bus.flag_e, bus.flag_gt}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with immediate, store qualifiers
        send(OP_ADD, 32'h10, 32'hDEADBEEF, 32'h4, 1'b1, 1'b0, 1'b1);
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_result", bus.alu_result, 32'h14);
        check("add_st_data", bus.st_data, 32'hDEADBEEF);
        check("add_is_st", 32'(bus.out_is_st), 32'd1);
        check("add_is_ld", 32'(bus.out_is_ld), 32'd0);
        @(posedge clk);
        #1;
        check("add_pulse_end", {30'd0, bus.out_valid, bus.out_is_st}, 32'd0);

        // back-to-back single-cycle ops
        send(OP_SUB, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0);
        check("sub_result", bus.alu_result, 32'hFFFFFFFE);
        check("sub_is_ld", 32'(bus.out_is_ld), 32'd1);
        send(OP_LSL, 32'd1, 32'd31, 32'h0, 1'b0, 1'b0, 1'b0);
        check("lsl_valid", 32'(bus.out_valid), 32'd1);
        check("lsl_result", bus.alu_result, 32'h80000000);
        send(OP_ASR, 32'h80000000, 32'd0, 32'd4, 1'b1, 1'b0, 1'b0);
        check("asr_valid", 32'(bus.out_valid), 32'd1);
        check("asr_result", bus.alu_result, 32'hF8000000);
        send(OP_LSR, 32'h80000000, 32'd0, 32'h24, 1'b1, 1'b0, 1'b0);
        check("lsr_result", bus.alu_result, 32'h08000000);
        send(OP_MUL, 32'h10000, 32'h10001, 32'h0, 1'b0, 1'b0, 1'b0);
        check("mul_result", bus.alu_result, 32'h00010000);
        send(OP_NOT, 32'h12345678, 32'h0, 32'h0F, 1'b1, 1'b0, 1'b0);
        check("not_result", bus.alu_result, 32'hFFFFFFF0);
        send(4'd14, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rsvd_valid", 32'(bus.out_valid), 32'd1);
        check("rsvd_result", bus.alu_result, 32'd0);

        // CMP flags
        send(OP_CMP, 32'd5, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1'b0);
        check("cmp_gt_flags", {30'd0, bus.flag_e, bus.flag_gt}, 32'd1);
        send(OP_CMP, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0);
        check("cmp_neg_flags", {30'd0, bus.flag_e, bus.flag_gt}, 32'd0);
        check("cmp_result", bus.alu_result, 32'd0);
        send(OP_CMP, 32'd3, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0);
        check("cmp_eq_flags", {30'd0, bus.flag_e, bus.flag_gt}, 32'd2);
        send(OP_ADD, 32'd7, 32'd8, 32'h0, 1'b0, 1'b0, 1'b0);
        check("add2_result", bus.alu_result, 32'd15);
        check("flags_hold", {30'd0, bus.flag_e, bus.flag_gt}, 32'd2);

        // asynchronous reset in the middle of a divide
        send(OP_DIV, 32'd100, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mrst_ready", 32'(bus.in_ready), 32'd1);
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_result", bus.alu_result, 32'd0);
        check("mrst_flags", {30'd0, bus.flag_e, bus.flag_gt}, 32'd0);
        check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(OP_ADD, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_result", bus.alu_result, 32'd3);

        // signed divides and special cases
        do_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        do_div("mod_m7_2", OP_MOD, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        do_div("div_100_m3", OP_DIV, 32'd100, 32'hFFFFFFFD, 32'hFFFFFFDF);
        do_div("mod_7_m2", OP_MOD, 32'd7, 32'hFFFFFFFE, 32'd1);
        do_div("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        do_div("mod_ovf", OP_MOD, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        do_div("div_9_0", OP_DIV, 32'd9, 32'd0, 32'hFFFFFFFF);
        do_div("mod_9_0", OP_MOD, 32'd9, 32'd0, 32'd9);

        // flush at accept+10 kills the divide
        send(OP_DIV, 32'd100, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_ready", 32'(bus.in_ready), 32'd1);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) pulses++;
        end
        check("flush_no_pulse", 32'(pulses), 32'd0);

        // ADD offered together with flush is dropped
        bus.alu_op = OP_ADD;
        bus.op1 = 32'd1;
        bus.op2 = 32'd1;
        bus.is_immediate = 1'b0;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        check("flush_add_valid", 32'(bus.out_valid), 32'd0);
        check("flush_add_result", bus.alu_result, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
